ddc_mixer_p: RTL and testbench
==============================

DDC_MIXER_P -- requirements
Module: ddc_mixer_p

Interface
REQ-001 The block SHALL have parameter LANES, default 4: number of parallel polyphase lanes.
REQ-002 The block SHALL have parameter SW, default 12: signed ADC sample width per lane.
REQ-003 The block SHALL have parameter LW, default 16: signed LO (cos/sin) width per lane.
REQ-004 The block SHALL have parameter OW, default 16: signed output width per lane.
REQ-005 The block SHALL have parameter SHIFT, default 11: number of product LSBs removed by rounding, legal range 1..SW+LW-1.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port valid_i, input, LANES bits: per-lane input-valid strobe.
REQ-009 The block SHALL have port sample_i, input, LANES*SW bits: lane n occupies bits [n*SW +: SW], signed.
REQ-010 The block SHALL have port cos_i, input, LANES*LW bits: lane n occupies bits [n*LW +: LW], signed.
REQ-011 The block SHALL have port sin_i, input, LANES*LW bits: lane n occupies bits [n*LW +: LW], signed.
REQ-012 The block SHALL have port conj_i, input, 1 bit: negate quadrature output when high.
REQ-013 The block SHALL have port ovf_clr_i, input, 1 bit: clear the sticky overflow flag.
REQ-014 The block SHALL have port inphase_o, output, LANES*OW bits: lane n occupies bits [n*OW +: OW], signed.
REQ-015 The block SHALL have port quadrature_o, output, LANES*OW bits: lane n occupies bits [n*OW +: OW], signed.
REQ-016 The block SHALL have port valid_o, output, LANES bits: per-lane output-valid strobe.
REQ-017 The block SHALL have port ovf_o, output, 1 bit: sticky saturation flag.

Function
REQ-018 The datapath SHALL have three register stages: input capture, full product, round/saturate; valid_i[n] high at edge k SHALL produce valid_o[n] high after edge k+2.
REQ-019 Each lane SHALL accept a new beat every cycle; there is no backpressure, and lanes SHALL be fully independent.
REQ-020 conj_i SHALL be captured together with the stage-1 data, so that a mid-stream change affects only beats sampled on or after the change.
REQ-021 Stage 2 SHALL compute the full signed products sample*cos and sample*sin at SW+LW bits; when the captured conj bit is set, the Q product SHALL be negated at SW+LW+1 bits without wrap.
REQ-022 Stage 3 SHALL round by adding 2^(SHIFT-1), arithmetic-shift right by SHIFT (round-half-up toward +inf), then saturate to [-2^(OW-1), 2^(OW-1)-1].
REQ-023 The data register of each stage and lane SHALL load only when that lane's stage valid is high, and otherwise SHALL hold its last value.
REQ-024 valid_o[n] SHALL be a one-cycle pulse per beat; consecutive beats SHALL give consecutive pulses.
REQ-025 ovf_o SHALL set on the edge at which any valid lane's I or Q saturates, and SHALL stay set until ovf_clr_i is sampled high.
REQ-026 When ovf_clr_i is high at the same edge as a new saturation event, the set SHALL win and ovf_o SHALL remain 1.

Reset
REQ-027 Asserting rst_i SHALL immediately clear all stage valids, valid_o, inphase_o, quadrature_o, ovf_o and all internal data registers to 0, regardless of the clock.
REQ-028 Beats in flight when rst_i asserts SHALL be discarded, and no valid_o SHALL appear for them after release.
REQ-029 The first beat sampled on the first rising edge after rst_i deasserts SHALL be processed normally.

Verification (LANES=4, SW=12, LW=16, OW=16, SHIFT=11)
REQ-030 The bench SHALL cover basic latency: valid_i=0001, sample0=100, cos0=16384, sin0=0 at edge k -> valid_o=0001 after edge k+2 only, inphase0=800, quadrature0=0.
REQ-031 The bench SHALL cover rounding: sample=1, cos=1024 -> I=1; sample=-1, cos=1024 -> I=0; sample=3, cos=1024 -> I=2.
REQ-032 The bench SHALL cover saturation and the sticky flag: sample=-2048, cos=-32768 -> I=32767 and ovf_o=1 at the same edge; ovf_o stays 1 over 10 idle cycles; a one-cycle ovf_clr_i pulse -> ovf_o=0; clear coincident with a new saturation -> ovf_o stays 1.
REQ-033 The bench SHALL cover conjugate mode: conj_i=1, sample=100, sin=16384 -> Q=-800; conj_i toggled back-to-back on consecutive beats -> Q alternates -800/800 with no cross-beat mixing.
REQ-034 The bench SHALL cover lane independence and hold: beat A on all lanes, then valid_i=0101 with new data -> lanes 0 and 2 update and lanes 1 and 3 hold beat-A values; valid_o=0101.
REQ-035 The bench SHALL cover reset mid-operation: three back-to-back beats, then rst_i asserted between edges -> all outputs and ovf_o are 0 immediately; after release, no stale valid_o; the next beat is processed with 3-stage latency.

Source files
------------

// File: rtl/ddc_mixer_p.sv
// Polyphase digital down-converter mixer.
// Each lane multiplies its ADC sample by a complex LO (cos, sin), rounds the
// products half-up, saturates them to OW bits and can conjugate the Q output.
// The three register stages per lane are capture -> product -> round/saturate.
// The saturation events of all lanes feed one sticky overflow flag.

module ddc_mixer_p_lane #(
  parameter int SW    = 12,
  parameter int LW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic signed [SW-1:0] sample_i,
  input  logic signed [LW-1:0] cos_i,
  input  logic signed [LW-1:0] sin_i,
  input  logic                 conj_i,
  output logic signed [OW-1:0] inphase_o,
  output logic signed [OW-1:0] quadrature_o,
  output logic                 valid_o,
  output logic                 sat_o
);
  localparam int PW = SW + LW;
  // The working width holds the negated Q product plus the rounding carry,
  // and it is never narrower than the output range being compared against.
  localparam int EW = (PW + 2 > OW + 1) ? PW + 2 : OW + 1;
  localparam logic signed [EW-1:0] RND  = {{(EW-1){1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [SW-1:0] s_q;
  logic signed [LW-1:0] c_q, n_q;
  logic                 cj_q, v1_q;
  logic signed [PW-1:0] pi_q, pi_d;
  logic signed [PW:0]   pq_q, pq_d, pq_raw;
  logic                 v2_q;
  logic signed [EW-1:0] ir, qr;
  logic signed [OW-1:0] i_q, q_q, i_d, q_d;
  logic                 si, sq, v3_q;

  // Stage 1: capture the sample, the LO and the conj bit of this beat together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q <= '0; c_q <= '0; n_q <= '0; cj_q <= 1'b0; v1_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        s_q <= sample_i; c_q <= cos_i; n_q <= sin_i; cj_q <= conj_i;
      end
    end
  end

  // Full-precision products. Q has one extra bit so that negating the most
  // negative product does not wrap.
  always_comb begin
    pi_d   = PW'(s_q) * PW'(c_q);
    pq_raw = (PW+1)'(s_q) * (PW+1)'(n_q);
    pq_d   = cj_q ? -pq_raw : pq_raw;
  end

  // Stage 2: product registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pi_q <= '0; pq_q <= '0; v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        pi_q <= pi_d; pq_q <= pq_d;
      end
    end
  end

  // Round half-up (add half an LSB, then floor), then clamp to the OW range.
  always_comb begin
    ir  = (EW'(pi_q) + RND) >>> SHIFT;
    qr  = (EW'(pq_q) + RND) >>> SHIFT;
    si  = (ir > MAXV) || (ir < MINV);
    sq  = (qr > MAXV) || (qr < MINV);
    i_d = (ir > MAXV) ? MAXV[OW-1:0] : (ir < MINV) ? MINV[OW-1:0] : ir[OW-1:0];
    q_d = (qr > MAXV) ? MAXV[OW-1:0] : (qr < MINV) ? MINV[OW-1:0] : qr[OW-1:0];
  end

  // Stage 3: output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q <= '0; q_q <= '0; v3_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        i_q <= i_d; q_q <= q_d;
      end
    end
  end

  assign inphase_o    = i_q;
  assign quadrature_o = q_q;
  assign valid_o      = v3_q;
  assign sat_o        = v2_q & (si | sq);
endmodule

module ddc_mixer_p #(
  parameter int LANES = 4,
  parameter int SW    = 12,
  parameter int LW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [LANES-1:0]      valid_i,
  input  logic [LANES*SW-1:0]   sample_i,
  input  logic [LANES*LW-1:0]   cos_i,
  input  logic [LANES*LW-1:0]   sin_i,
  input  logic                  conj_i,
  input  logic                  ovf_clr_i,
  output logic [LANES*OW-1:0]   inphase_o,
  output logic [LANES*OW-1:0]   quadrature_o,
  output logic [LANES-1:0]      valid_o,
  output logic                  ovf_o
);
  logic [LANES-1:0] sat;
  logic             ovf_q, ovf_d;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    ddc_mixer_p_lane #(.SW(SW), .LW(LW), .OW(OW), .SHIFT(SHIFT)) u_lane (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .valid_i      (valid_i[n]),
      .sample_i     (sample_i[n*SW +: SW]),
      .cos_i        (cos_i[n*LW +: LW]),
      .sin_i        (sin_i[n*LW +: LW]),
      .conj_i       (conj_i),
      .inphase_o    (inphase_o[n*OW +: OW]),
      .quadrature_o (quadrature_o[n*OW +: OW]),
      .valid_o      (valid_o[n]),
      .sat_o        (sat[n])
    );
  end

  // A new saturation takes priority over a clear arriving on the same edge.
  always_comb ovf_d = (|sat) | (ovf_q & ~ovf_clr_i);

  // Sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
endmodule

// File: tb/tb_ddc_mixer_p.sv
// Randomized and directed bench for ddc_mixer_p with a delay-line reference model.
module tb_ddc_mixer_p;
  localparam int L = 4, SW = 12, LW = 16, OW = 16, SH = 11;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [L-1:0]    valid_i = '0;
  logic [L*SW-1:0] sample_i = '0;
  logic [L*LW-1:0] cos_i = '0, sin_i = '0;
  logic            conj_i = 1'b0, ovf_clr_i = 1'b0;
  logic [L*OW-1:0] inphase_o, quadrature_o;
  logic [L-1:0]    valid_o;
  logic            ovf_o;

  ddc_mixer_p #(.LANES(L), .SW(SW), .LW(LW), .OW(OW), .SHIFT(SH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .sample_i(sample_i),
    .cos_i(cos_i), .sin_i(sin_i), .conj_i(conj_i), .ovf_clr_i(ovf_clr_i),
    .inphase_o(inphase_o), .quadrature_o(quadrature_o), .valid_o(valid_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int npass = 0, ntot = 0;

  // Model: beats sampled on the last three edges (index 2 = two edges ago).
  logic [L-1:0] pv [3];
  int           ps [3][L], pc [3][L], pn [3][L];
  bit           pcj [3];
  int           ei [L], eq [L];
  logic [L-1:0] ev;
  bit           eovf;

  task automatic chk(input string tag, input longint got, input longint exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Ideal result: exact product, optional negation, floor(x + 1/2) at 2^-SH, clamp.
  function automatic void mdl(input int s, input int lo, input bit neg, output int o, output bit sat);
    longint p;
    p = longint'(s) * longint'(lo);
    if (neg) p = -p;
    p = (p + (longint'(1) << (SH-1))) >>> SH;
    sat = (p > 32767) || (p < -32768);
    o = (p > 32767) ? 32767 : (p < -32768) ? -32768 : int'(p);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin pv[i] = '0; pcj[i] = 0; end
    for (int n = 0; n < L; n++) begin ei[n] = 0; eq[n] = 0; end
    ev = '0; eovf = 0;
  endtask

  task automatic set_lane(input int n, input int s, input int c, input int sn);
    sample_i[n*SW +: SW] = SW'(s);
    cos_i[n*LW +: LW]    = LW'(c);
    sin_i[n*LW +: LW]    = LW'(sn);
  endtask

  task automatic check_outs(input string pfx);
    chk({pfx, "valid_o"}, longint'(valid_o), longint'(ev));
    chk({pfx, "ovf_o"}, longint'(ovf_o), longint'(eovf));
    for (int n = 0; n < L; n++) begin
      chk($sformatf("%sI%0d", pfx, n), longint'($signed(inphase_o[n*OW +: OW])), longint'(ei[n]));
      chk($sformatf("%sQ%0d", pfx, n), longint'($signed(quadrature_o[n*OW +: OW])), longint'(eq[n]));
    end
  endtask

  // One clock edge: advance the model, then compare just after the edge.
  task automatic tick();
    bit sat_any, si, sq;
    @(posedge clk_i);
    for (int i = 2; i > 0; i--) begin
      pv[i] = pv[i-1]; pcj[i] = pcj[i-1];
      for (int n = 0; n < L; n++) begin
        ps[i][n] = ps[i-1][n]; pc[i][n] = pc[i-1][n]; pn[i][n] = pn[i-1][n];
      end
    end
    pv[0] = valid_i; pcj[0] = conj_i;
    for (int n = 0; n < L; n++) begin
      ps[0][n] = $signed(sample_i[n*SW +: SW]);
      pc[0][n] = $signed(cos_i[n*LW +: LW]);
      pn[0][n] = $signed(sin_i[n*LW +: LW]);
    end
    sat_any = 0;
    for (int n = 0; n < L; n++)
      if (pv[2][n]) begin
        mdl(ps[2][n], pc[2][n], 1'b0, ei[n], si);
        mdl(ps[2][n], pn[2][n], pcj[2], eq[n], sq);
        sat_any |= si | sq;
      end
    ev = pv[2];
    eovf = sat_any | (eovf & !ovf_clr_i);
    #1;
    check_outs("");
  endtask

  task automatic idle(input int k);
    valid_i = '0;
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic beat0(input int s, input int c, input int sn);
    set_lane(0, s, c, sn); valid_i = 4'b0001; tick(); idle(2);
  endtask

  initial begin
    model_clear();
    #2;
    check_outs("rst_");
    @(negedge clk_i); rst_i = 1'b0;

    // basic latency
    set_lane(0, 100, 16384, 0); valid_i = 4'b0001; tick();
    idle(1);
    chk("basic_early_valid", longint'(valid_o), 0);
    idle(1);
    chk("basic_valid", longint'(valid_o), 1);
    chk("basic_I", longint'($signed(inphase_o[15:0])), 800);

    // rounding
    beat0(1, 1024, 0);  chk("rnd_p1", longint'($signed(inphase_o[15:0])), 1);
    beat0(-1, 1024, 0); chk("rnd_m1", longint'($signed(inphase_o[15:0])), 0);
    beat0(3, 1024, 0);  chk("rnd_p3", longint'($signed(inphase_o[15:0])), 2);

    // saturation and sticky flag
    beat0(-2048, -32768, 0);
    chk("sat_I", longint'($signed(inphase_o[15:0])), 32767);
    chk("sat_ovf", longint'(ovf_o), 1);
    idle(10);
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    chk("ovf_cleared", longint'(ovf_o), 0);
    set_lane(0, -2048, -32768, 0); valid_i = 4'b0001; tick();
    valid_i = '0; tick();
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    chk("ovf_set_wins", longint'(ovf_o), 1);
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;

    // conjugate mode, including back-to-back toggling
    conj_i = 1'b1; beat0(100, 0, 16384);
    chk("conj_Q", longint'($signed(quadrature_o[15:0])), -800);
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 100, 0, 16384); conj_i = (i % 2 == 0); valid_i = 4'b0001; tick();
    end
    conj_i = 1'b0; idle(2);
    chk("conj_last_Q", longint'($signed(quadrature_o[15:0])), 800);

    // lane independence and hold
    for (int n = 0; n < L; n++) set_lane(n, 10*(n+1), 4096, -4096);
    valid_i = 4'hF; tick();
    for (int n = 0; n < L; n++) set_lane(n, -50*(n+1), 8192, 2048);
    valid_i = 4'b0101; tick();
    idle(1);
    idle(1);
    chk("indep_valid", longint'(valid_o), 5);
    chk("indep_hold_I1", longint'($signed(inphase_o[31:16])), 40);

    // reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < L; n++) set_lane(n, 200+i, 16384, 16384);
      valid_i = 4'hF; tick();
    end
    #2 rst_i = 1'b1;
    #1;
    model_clear();
    check_outs("midrst_");
    @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    idle(3);
    beat0(100, 16384, 0);
    chk("post_rst_I", longint'($signed(inphase_o[15:0])), 800);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < L; n++) begin
        if ($urandom_range(0, 7) == 0) set_lane(n, -2048, -32768, ($urandom_range(0, 1) != 0) ? -32768 : 32767);
        else set_lane(n, int'($urandom_range(0, 4095)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      end
      valid_i   = L'($urandom_range(0, 15));
      conj_i    = ($urandom_range(0, 1) != 0);
      ovf_clr_i = ($urandom_range(0, 5) == 0);
      tick();
    end
    ovf_clr_i = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
